ahb_burst_rr_scheduler: RTL and testbench

AHB_BURST_RR_SCHEDULER -- requirements
Module: ahb_burst_rr_scheduler

---
 rtl/ahb_burst_rr_scheduler.sv | 173 +++++++++++++++++
 tb/tb_ahb_burst_rr_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_rr_scheduler.sv
// AHB burst-aware round-robin scheduler: grants one of MASTER_NUM masters access to a shared slave.
// Latency: 1 cycle from request to grant; back-to-back handover on hlast with no idle bubble.
// Backpressure: hready=0 freezes beat counting and arbitration while BUSY.
//
// Ports: hclk/hreset (async, active-high); hreq, hburst per master; hready from slave;
//        hgrant (one-hot, registered), hmaster (registered index), hsel (any grant),
//        hlast (combinational, final completing beat of the current transaction).
// Optional: define AHB_WRR_WEIGHT_EN to add weight_cfg and weighted round-robin
//           (a master keeps the grant for up to weight_cfg[i]+1 back-to-back transactions).
module ahb_burst_rr_scheduler #(
  parameter int MASTER_NUM = 4,
  parameter int WEIGHT_BIT = 2
) (
  input  logic                                   hclk,
  input  logic                                   hreset,
  input  logic [MASTER_NUM-1:0]                  hreq,
  input  logic [MASTER_NUM-1:0][2:0]             hburst,
  input  logic                                   hready,
`ifdef AHB_WRR_WEIGHT_EN
  input  logic [MASTER_NUM-1:0][WEIGHT_BIT-1:0]  weight_cfg,
`endif
  output logic [MASTER_NUM-1:0]                  hgrant,
  output logic [$clog2(MASTER_NUM)-1:0]          hmaster,
  output logic                                   hsel,
  output logic                                   hlast
);

  localparam int IDX_W = $clog2(MASTER_NUM);

  if (MASTER_NUM < 2 || MASTER_NUM > 16 || WEIGHT_BIT < 1) begin : g_bad_cfg
    $error("ahb_burst_rr_scheduler: unsupported MASTER_NUM/WEIGHT_BIT");
  end

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [MASTER_NUM-1:0]  grant_d;
  logic [IDX_W-1:0]       master_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             burst_q, burst_d;
  logic [IDX_W-1:0]       last_ptr_q, last_ptr_d;

  logic [IDX_W-1:0]       ptr;
  logic [MASTER_NUM-1:0]  others;
  logic [MASTER_NUM-1:0]  elig;
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand_idx;
  logic                   keep;

`ifdef AHB_WRR_WEIGHT_EN
  logic [WEIGHT_BIT-1:0]  credit_q, credit_d;
`endif

  // Index of the final beat: SINGLE=1 beat, 4/8/16-beat types, INCR capped at 16.
  function automatic logic [3:0] last_beat(input logic [2:0] b);
    case (b)
      3'd0:       last_beat = 4'd0;
      3'd2, 3'd3: last_beat = 4'd3;
      3'd4, 3'd5: last_beat = 4'd7;
      default:    last_beat = 4'd15;
    endcase
  endfunction

  assign hsel  = |hgrant;
  assign hlast = (state_q == BUSY) && hready &&
                 ((cnt_q == last_beat(burst_q)) ||
                  (burst_q == BURST_INCR && !hreq[hmaster]));

  // On handover the current owner only competes when nobody else is asking,
  // so the search starts just above it and excludes it if possible.
  always_comb begin
    ptr      = (state_q == BUSY) ? hmaster : last_ptr_q;
    others   = hreq & ~hgrant;
    elig     = (state_q == BUSY && |others) ? others : hreq;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      cand_idx = IDX_W'((int'(ptr) + i) % MASTER_NUM);
      if (!win_vld && elig[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

`ifdef AHB_WRR_WEIGHT_EN
  assign keep = (state_q == BUSY) && (credit_q != '0) && hreq[hmaster];
`else
  assign keep = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = hgrant;
    master_d   = hmaster;
    cnt_d      = cnt_q;
    burst_d    = burst_q;
    last_ptr_d = last_ptr_q;
`ifdef AHB_WRR_WEIGHT_EN
    credit_d   = credit_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = BUSY;
          grant_d  = MASTER_NUM'(1) << win_idx;
          master_d = win_idx;
          cnt_d    = '0;
          burst_d  = hburst[win_idx];
`ifdef AHB_WRR_WEIGHT_EN
          credit_d = weight_cfg[win_idx];
`endif
        end
      end
      default: begin
        if (hlast) begin
          last_ptr_d = hmaster;
          cnt_d      = '0;
          if (keep) begin
            // Weighted repeat: same owner, fresh transaction, one credit spent.
            burst_d  = hburst[hmaster];
`ifdef AHB_WRR_WEIGHT_EN
            credit_d = credit_q - 1'b1;
`endif
          end else if (win_vld) begin
            grant_d  = MASTER_NUM'(1) << win_idx;
            master_d = win_idx;
            burst_d  = hburst[win_idx];
`ifdef AHB_WRR_WEIGHT_EN
            credit_d = weight_cfg[win_idx];
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (hready) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= IDLE;
      hgrant     <= '0;
      hmaster    <= '0;
      cnt_q      <= '0;
      burst_q    <= BURST_SINGLE;
      last_ptr_q <= IDX_W'(MASTER_NUM - 1);
    end else begin
      state_q    <= state_d;
      hgrant     <= grant_d;
      hmaster    <= master_d;
      cnt_q      <= cnt_d;
      burst_q    <= burst_d;
      last_ptr_q <= last_ptr_d;
    end
  end

`ifdef AHB_WRR_WEIGHT_EN
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) credit_q <= '0;
    else        credit_q <= credit_d;
  end
`endif

endmodule

// File: tb/tb_ahb_burst_rr_scheduler.sv
// Directed bench for ahb_burst_rr_scheduler (MASTER_NUM=4, WEIGHT_BIT=2).
// Latency: n/a.
// Backpressure: hready toggled explicitly per scenario.
module tb_ahb_burst_rr_scheduler;

  logic             hclk;
  logic             hreset;
  logic [3:0]       hreq;
  logic [3:0][2:0]  hburst;
  logic             hready;
  logic [3:0]       hgrant;
  logic [1:0]       hmaster;
  logic             hsel;
  logic             hlast;
`ifdef AHB_WRR_WEIGHT_EN
  logic [3:0][1:0]  weight_cfg;
`endif

  int n_chk = 0;
  int n_err = 0;

  ahb_burst_rr_scheduler #(.MASTER_NUM(4), .WEIGHT_BIT(2)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .hreq    (hreq),
    .hburst  (hburst),
    .hready  (hready),
`ifdef AHB_WRR_WEIGHT_EN
    .weight_cfg (weight_cfg),
`endif
    .hgrant  (hgrant),
    .hmaster (hmaster),
    .hsel    (hsel),
    .hlast   (hlast)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  logic [9:0] rdy_pat;
  logic [1:0] exp_pat [8];

  initial begin
    hreset = 1'b1;
    hreq   = '0;
    hburst = '0;
    hready = 1'b1;
`ifdef AHB_WRR_WEIGHT_EN
    weight_cfg = '0;
`endif

    // Reset state
    tick(); tick();
    check("rst_hgrant", hgrant, 4'b0000);
    check("rst_hmaster", hmaster, 2'd0);
    check("rst_hsel", hsel, 1'b0);
    check("rst_hlast", hlast, 1'b0);

    // Two SINGLE requesters alternate with no bubble
    hreset = 1'b0;
    hreq   = 4'b0101;
    tick();
    check("rr_c1_grant", hgrant, 4'b0001);
    check("rr_c1_master", hmaster, 2'd0);
    check("rr_c1_hsel", hsel, 1'b1);
    check("rr_c1_hlast", hlast, 1'b1);
    tick();
    check("rr_c2_grant", hgrant, 4'b0100);
    check("rr_c2_master", hmaster, 2'd2);
    tick();
    check("rr_c3_grant", hgrant, 4'b0001);
    hreq = 4'b0000;
    tick();
    check("rr_idle_grant", hgrant, 4'b0000);
    check("rr_idle_hsel", hsel, 1'b0);

    // Master 1 INCR8 with two wait states; request dropped mid-burst
    hburst[1] = 3'd5;
    hreq      = 4'b0010;
    tick();
    check("incr8_grant", hgrant, 4'b0010);
    rdy_pat = 10'b1111101011; // bit c-1 = hready at cycle c
    for (int c = 1; c <= 10; c++) begin
      hready = rdy_pat[c-1];
      hreq   = (c >= 5) ? 4'b0000 : 4'b0010;
      #1;
      check($sformatf("incr8_hlast_c%0d", c), hlast, (c == 10));
      check($sformatf("incr8_hold_c%0d", c), hgrant, 4'b0010);
      tick();
    end
    check("incr8_end_grant", hgrant, 4'b0000);
    hready = 1'b1;

    // Master 3 INCR held high: capped at 16 beats, hands over to master 0
    hburst[1] = 3'd0;
    hburst[3] = 3'd1;
    hreq      = 4'b1000;
    tick();
    check("incr_grant", hgrant, 4'b1000);
    for (int b = 1; b <= 16; b++) begin
      hreq = (b >= 10) ? 4'b1001 : 4'b1000;
      #1;
      check($sformatf("incr_hlast_b%0d", b), hlast, (b == 16));
      tick();
    end
    check("incr_handover_grant", hgrant, 4'b0001);
    check("incr_handover_master", hmaster, 2'd0);
    hreq = 4'b1000;
    tick();
    check("incr_back_grant", hgrant, 4'b1000);
    for (int b = 1; b <= 16; b++) begin
      #1;
      check($sformatf("incr2_hlast_b%0d", b), hlast, (b == 16));
      tick();
    end
    check("incr_regrant_same", hgrant, 4'b1000);
    // INCR ends early when the owner drops its request
    for (int b = 1; b <= 3; b++) begin
      hreq = (b == 3) ? 4'b0000 : 4'b1000;
      #1;
      check($sformatf("incr_drop_hlast_b%0d", b), hlast, (b == 3));
      tick();
    end
    check("incr_drop_idle", hgrant, 4'b0000);

    // Reset mid-WRAP4 drops grant asynchronously; no resume
    hburst[3] = 3'd2;
    hreq      = 4'b1000;
    tick();
    check("wrap4_grant", hgrant, 4'b1000);
    tick();
    #2;
    hreset = 1'b1;
    #1;
    check("async_rst_grant", hgrant, 4'b0000);
    check("async_rst_hsel", hsel, 1'b0);
    check("async_rst_hlast", hlast, 1'b0);
    tick();
    hreset = 1'b0;
    tick();
    check("post_rst_grant", hgrant, 4'b1000);
    check("post_rst_master", hmaster, 2'd3);
    for (int c = 1; c <= 4; c++) begin
      hreq = (c == 4) ? 4'b0000 : 4'b1000;
      #1;
      check($sformatf("wrap4_hlast_c%0d", c), hlast, (c == 4));
      tick();
    end
    check("wrap4_end_grant", hgrant, 4'b0000);

    // Masters 0 and 1 requesting SINGLE, weight_cfg[0]=2
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    hburst = '0;
    hreq   = 4'b0011;
`ifdef AHB_WRR_WEIGHT_EN
    weight_cfg[0] = 2'd2;
    exp_pat = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
`else
    exp_pat = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("pat_master_%0d", k), hmaster, exp_pat[k]);
      check($sformatf("pat_onehot_%0d", k), hgrant, 4'b0001 << exp_pat[k]);
    end
    hreq = 4'b0000;
    tick();
    tick();
    check("final_idle", hsel, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
